// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with a two-entry skid buffer.
// The stage splits an instruction word into opcode, rs1, rs2, rd and an
// extended immediate, and flags opcodes outside the implemented set.
// Outputs always present the main register M. S absorbs one extra entry
// under backpressure so that in_ready can be a plain register.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | M and S invalid
// ST_ONE   | M valid, S invalid
// ST_TWO   | M and S valid, in_ready low until M drains
module decode_stage #(
    parameter int INSTR_W    = 19,
    parameter int OPC_W      = 5,
    parameter int REG_W      = 4,
    parameter int IMM_W      = 10,
    parameter int XLEN       = 16,
    parameter int NUM_OPS    = 24,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_rs1,
    output logic [REG_W-1:0]   out_rs2,
    output logic [REG_W-1:0]   out_rd,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_illegal,
    output logic [7:0]         illegal_count
);

    // Payload layout: {opcode, rs1, rs2, rd, imm, illegal}
    localparam int DW = OPC_W + 3*REG_W + XLEN + 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [OPC_W:0] NUM_OPS_W = (OPC_W+1)'(NUM_OPS);

    logic [OPC_W-1:0] dec_opc;
    logic [REG_W-1:0] dec_rs1;
    logic [REG_W-1:0] dec_rs2;
    logic [REG_W-1:0] dec_rd;
    logic [IMM_W-1:0] imm_raw;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic [DW-1:0]    dec_word;

    logic [1:0]    state_q, state_d;
    logic          m_valid_q, m_valid_d;
    logic          in_ready_q, in_ready_d;
    logic [DW-1:0] m_q, m_d;
    logic [DW-1:0] s_q, s_d;
    logic [7:0]    cnt_q, cnt_d;

    logic accept;
    logic emit;

    assign dec_opc     = in_instr[INSTR_W-1 -: OPC_W];
    assign dec_rs1     = in_instr[INSTR_W-OPC_W-1 -: REG_W];
    assign dec_rs2     = in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign dec_rd      = in_instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
    assign imm_raw     = in_instr[IMM_W-1:0];
    assign dec_illegal = ({1'b0, dec_opc} >= NUM_OPS_W);

    // Immediate extension chosen at elaboration time.
    generate
        if (XLEN == IMM_W) begin : g_imm_plain
            assign dec_imm = imm_raw;
        end else if (IMM_SIGNED) begin : g_imm_sext
            assign dec_imm = {{(XLEN-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
        end else begin : g_imm_zext
            assign dec_imm = {{(XLEN-IMM_W){1'b0}}, imm_raw};
        end
    endgenerate

    assign dec_word = {dec_opc, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_illegal};

    assign accept = in_valid && in_ready_q;
    assign emit   = m_valid_q && out_ready;

    // Skid-buffer sequencing and illegal counter next-state.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_d     = dec_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    m_d = dec_word;
                end else if (accept) begin
                    s_d     = dec_word;
                    state_d = ST_TWO;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (emit) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush discards held entries; payloads may still load but stay invalid.
        if (flush) begin
            state_d = ST_EMPTY;
        end
        if (accept && dec_illegal && !flush && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        m_valid_d  = (state_d != ST_EMPTY);
        in_ready_d = (state_d != ST_TWO);
    end

    // State, payload and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            m_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            m_q        <= '0;
            s_q        <= '0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            in_ready_q <= in_ready_d;
            m_q        <= m_d;
            s_q        <= s_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = m_valid_q;
    assign out_opcode    = m_q[DW-1 -: OPC_W];
    assign out_rs1       = m_q[XLEN+3*REG_W -: REG_W];
    assign out_rs2       = m_q[XLEN+2*REG_W -: REG_W];
    assign out_rd        = m_q[XLEN+REG_W -: REG_W];
    assign out_imm       = m_q[XLEN:1];
    assign out_illegal   = m_q[0];
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes hand-computed
// expectations on accept, an independent monitor pops them on every emit.
// A second instance with zero-extended immediates shares all inputs.
module tb_decode_stage;

    typedef struct packed {
        logic [18:0] instr;
        logic [4:0]  opc;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [15:0] imm;
        logic [15:0] immu;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [3:0]  out_rs1, out_rs2, out_rd;
    logic [15:0] out_imm;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    logic        u_in_ready, u_out_valid, u_out_illegal;
    logic [4:0]  u_out_opcode;
    logic [3:0]  u_out_rs1, u_out_rs2, u_out_rd;
    logic [15:0] u_out_imm;
    logic [7:0]  u_illegal_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    vec_t tbl [7];
    vec_t sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_opcode(out_opcode), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    decode_stage #(.IMM_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_opcode(u_out_opcode), .out_rs1(u_out_rs1),
        .out_rs2(u_out_rs2), .out_rd(u_out_rd), .out_imm(u_out_imm),
        .out_illegal(u_out_illegal), .illegal_count(u_illegal_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one vector until accepted, then record its expected decode.
    task automatic send(input int idx);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = tbl[idx].instr;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 (vector %0d)", idx);
        end else begin
            sb_q.push_back(tbl[idx]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: every emit must match the oldest outstanding expectation.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got opcode %0h expected no output", out_opcode);
                end else begin
                    e = sb_q.pop_front();
                    chk("opcode",  32'(out_opcode),  32'(e.opc));
                    chk("rs1",     32'(out_rs1),     32'(e.rs1));
                    chk("rs2",     32'(out_rs2),     32'(e.rs2));
                    chk("rd",      32'(out_rd),      32'(e.rd));
                    chk("imm",     32'(out_imm),     32'(e.imm));
                    chk("illegal", 32'(out_illegal), 32'(e.ill));
                    chk("imm_zext", 32'(u_out_imm),  32'(e.immu));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int c0;
        tbl[0] = '{19'h0C965, 5'd3,  4'h2, 4'h5, 4'h9, 16'h0165, 16'h0165, 1'b0};
        tbl[1] = '{19'h0C7FF, 5'd3,  4'h1, 4'hF, 4'hF, 16'hFFFF, 16'h03FF, 1'b0};
        tbl[2] = '{19'h78000, 5'd30, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b1};
        tbl[3] = '{19'h00000, 5'd0,  4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{19'h5FC00, 5'd23, 4'hF, 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0};
        tbl[5] = '{19'h60000, 5'd24, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b1};
        tbl[6] = '{19'h1A2B4, 5'd6,  4'h8, 4'hA, 4'hD, 16'hFEB4, 16'h02B4, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_opcode",    32'(out_opcode), 32'd0);
        chk("rst_imm",       32'(out_imm),   32'd0);
        chk("rst_illegal",   32'(out_illegal), 32'd0);
        chk("rst_count",     32'(illegal_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic decode, sign extension, illegal opcode
        out_ready = 1'b1;
        send(0);
        chk("latency_valid",  32'(out_valid),  32'd1);
        chk("latency_opcode", 32'(out_opcode), 32'd3);
        in_valid = 1'b0;
        drain();
        send(1);
        send(2);
        in_valid = 1'b0;
        drain();
        chk("count_one", 32'(illegal_count), 32'd1);

        // Full throughput with out_ready held high
        c0 = cyc;
        send(3); send(4); send(5); send(6);
        in_valid = 1'b0;
        chk("throughput_cycles", 32'(cyc - c0), 32'd4);
        drain();
        chk("count_two", 32'(illegal_count), 32'd2);

        // Backpressure: A in M, B skids into S, then in_ready drops
        send(3);
        out_ready = 1'b0;
        send(4);
        chk("bp_in_ready",  32'(in_ready),   32'd0);
        chk("bp_out_valid", 32'(out_valid),  32'd1);
        chk("bp_hold_a",    32'(out_opcode), 32'd0);
        in_valid = 1'b1;
        in_instr = tbl[5].instr;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(5);
        send(6);
        in_valid = 1'b0;
        drain();
        chk("count_three", 32'(illegal_count), 32'd3);

        // Flush in TWO: M emitted this cycle, S dropped
        out_ready = 1'b0;
        send(0);
        send(1);
        in_valid = 1'b1; in_instr = tbl[2].instr; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_out_valid", 32'(out_valid), 32'd0);
        chk("flush2_in_ready",  32'(in_ready),  32'd1);
        chk("flush2_count",     32'(illegal_count), 32'd3);
        chk("flush2_dropped",   32'(sb_q.size()), 32'd1);
        sb_q.delete();

        // Flush in ONE with a same-cycle illegal accept that must be discarded
        out_ready = 1'b0;
        send(0);
        in_valid = 1'b1; in_instr = tbl[2].instr; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_out_valid", 32'(out_valid), 32'd0);
        chk("flush1_in_ready",  32'(in_ready),  32'd1);
        chk("flush1_count",     32'(illegal_count), 32'd3);
        chk("flush1_dropped",   32'(sb_q.size()), 32'd1);
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush1_stays_empty", 32'(out_valid), 32'd0);

        // Counter saturation
        for (int i = 0; i < 300; i++) send(2);
        in_valid = 1'b0;
        drain();
        chk("count_saturated", 32'(illegal_count), 32'd255);

        // Asynchronous reset between edges while in ONE
        out_ready = 1'b0;
        send(1);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_count",     32'(illegal_count), 32'd0);
        chk("arst_opcode",    32'(out_opcode), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        drain();
        chk("post_rst_count", 32'(illegal_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage. It splits an instruction word into opcode, rs1, rs2, rd and an extended immediate, and flags opcodes outside the implemented set as illegal. Input and output use valid/ready handshakes, and a 2-entry skid buffer sustains one instruction per cycle under backpressure. It sits between the fetch stage and the register-file read / execute stage, and adds flush support and an illegal-instruction counter.

## Interface
Parameters:
- INSTR_W, 19: instruction width; must equal OPC_W + REG_W + IMM_W.
- OPC_W, 5: opcode width.
- REG_W, 4: register-address width.
- IMM_W, 10: immediate width; must satisfy IMM_W >= 2*REG_W.
- XLEN, 16: width of the extended immediate; must satisfy XLEN >= IMM_W.
- NUM_OPS, 24: number of legal opcodes; any opcode >= NUM_OPS is illegal.
- IMM_SIGNED, 1: 1 = sign-extend the immediate, 0 = zero-extend.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  INSTR_W  instruction word.
- flush  in  1  discard all held instructions.
- out_valid  out  1  decoded outputs are valid.
- out_ready  in  1  downstream accepts.
- out_opcode  out  OPC_W  opcode = instr[INSTR_W-1 -: OPC_W].
- out_rs1  out  REG_W  source register 1, the next REG_W bits below the opcode.
- out_rs2  out  REG_W  source register 2, the next REG_W bits below rs1.
- out_rd  out  REG_W  destination register, the next REG_W bits below rs2; the remaining low bits are unused.
- out_imm  out  XLEN  instr[IMM_W-1:0], extended per IMM_SIGNED; overlaps rs2/rd.
- out_illegal  out  1  out_opcode >= NUM_OPS.
- illegal_count  out  8  count of accepted illegal instructions; saturates.

## Operation
- Decode is combinational on in_instr. The result is captured into the main register (M) or the skid register (S).
- Accept event: in_valid && in_ready. Emit event: out_valid && out_ready.
- The outputs always present M. out_valid = M valid.
- State machine:
  - EMPTY (M and S invalid):
    - accept → ONE.
  - ONE (M valid, S invalid):
    - accept with emit → ONE (M reloads).
    - accept without emit → TWO (new entry goes to S).
    - emit without accept → EMPTY.
  - TWO (M and S valid):
    - in_ready = 0.
    - emit → ONE (S moves into M).
    - no emit → hold.
- in_ready = !S valid, registered. It is 1 in EMPTY and ONE, and 0 in TWO.
- Ordering is strictly FIFO. No instruction is dropped or duplicated except by flush.
- Immediate:
  - IMM_SIGNED = 1: out_imm = {{(XLEN-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]}.
  - IMM_SIGNED = 0: upper bits are zero.
  - If XLEN == IMM_W, no extension is applied.
- Illegal instructions are still passed downstream with out_illegal = 1. The stage does not stall on them.
- illegal_count increments by 1 on each accept of an illegal instruction. It saturates at 255 and is cleared only by rst.
- flush (synchronous):
  - Next edge: M and S invalid, state EMPTY, in_ready = 1.
  - A same-cycle accept is discarded and does not increment illegal_count.
  - A same-cycle emit is counted as delivered.
- When a register is invalid, its payload holds its last value; it is not cleared.

## Timing
- Latency: an instruction accepted at edge N is on the outputs with out_valid = 1 after edge N.
- Throughput: 1 instruction per cycle while out_ready = 1.
- After out_ready deasserts with M full, one further instruction is absorbed into S, then in_ready falls.
- in_ready returns to 1 on the edge after the cycle in which S drains.
- out_* and in_ready are driven only from registers; there is no combinational path from in_* to out_*.
- Reset values (asynchronous, held while rst = 1): out_valid = 0, in_ready = 1, out_opcode/rs1/rs2/rd/imm = 0, out_illegal = 0, illegal_count = 0, state EMPTY.
- rst asserted mid-operation discards M and S immediately, without waiting for a clock edge.

## Test plan
All scenarios use default parameters.
- Basic decode:
  - Stimulus: in_instr = 19'h0C965, out_ready = 1.
  - Response: one cycle later, out_valid = 1, opcode = 3, rs1 = 2, rs2 = 5, rd = 9, imm = 16'h0165, illegal = 0.
- Sign extension:
  - Stimulus: in_instr = 19'h0C7FF.
  - Response: rs1 = 1, rs2 = F, rd = F, imm = 16'hFFFF.
  - With IMM_SIGNED = 0: imm = 16'h03FF.
- Illegal opcode:
  - Stimulus: in_instr = 19'h78000 (opcode 30).
  - Response: out_illegal = 1, instruction delivered, illegal_count = 1.
  - Stimulus: 300 illegal accepts.
  - Response: illegal_count = 255.
- Backpressure:
  - Stimulus: stream A, B, C, D with out_ready = 0 for 3 cycles after A is accepted.
  - Response: B goes to S, then in_ready = 0.
  - Response: after out_ready = 1, outputs appear as A, B, C, D with no loss and no duplication.
  - Response: with out_ready held at 1, full throughput of 1 instruction per cycle.
- Flush:
  - Stimulus: in state TWO, assert flush with in_valid = 1.
  - Response: next cycle out_valid = 0, in_ready = 1; the same-cycle input is dropped.
  - Response: an illegal instruction dropped this way does not increment illegal_count.
- Async reset:
  - Stimulus: assert rst between clock edges while in state ONE.
  - Response: out_valid = 0 and illegal_count = 0 immediately.
  - Response: a decode after reset release behaves as in the basic decode scenario.
